// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage_pkg
// Description : Shared CPU constants for the fetch stage: branch opcodes,
//               erased-memory HALT word, FSM encoding, branch-target helper.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_stage_pkg;

   localparam logic [5:0]  OPC_BEQ   = 6'b101000;
   localparam logic [5:0]  OPC_BNE   = 6'b101001;
   localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

   localparam int STATE_W = 1;
   typedef logic [STATE_W-1:0] state_t;
   localparam state_t ST_RUN  = 1'b0;
   localparam state_t ST_HALT = 1'b1;

   // Only imm[13:0] survives the <<2 and the 16-bit truncation.
   function automatic logic [15:0] branch_target(input logic [15:0] pc4,
                                                 input logic [13:0] imm_lo);
      branch_target = pc4 + {imm_lo, 2'b00};
   endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_stage_predecode.sv
`default_nettype none
// ============================================================================
// Module      : fetch_predecode
// Description : Fetch predecode: PC+4, HALT-word detect and next-PC selection.
//               Backward-taken prediction enabled by FETCH_BTFN_PREDICT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_predecode
   import fetch_stage_pkg::*;
(
   input  logic [15:0] pc_i,
   input  logic [31:0] instr_i,
   output logic [15:0] pc4_o,
   output logic [15:0] next_pc_o,
   output logic        pred_taken_o,
   output logic        is_halt_o
);

   assign pc4_o     = pc_i + 16'd4;
   assign is_halt_o = (instr_i == HALT_WORD);

`ifdef FETCH_BTFN_PREDICT_EN
   logic        is_cond_branch;
   logic [15:0] target;

   assign is_cond_branch = (instr_i[31:26] == OPC_BEQ) || (instr_i[31:26] == OPC_BNE);
   assign target         = branch_target(pc4_o, instr_i[13:0]);
   // A negative displacement marks a loop back-edge: predict it taken.
   assign pred_taken_o   = is_cond_branch && instr_i[15];
   assign next_pc_o      = pred_taken_o ? target : pc4_o;
`else
   assign pred_taken_o   = 1'b0;
   assign next_pc_o      = pc4_o;
`endif

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction fetch: PC register, IF/ID pipeline register and
//               RUN/HALT FSM. Optional feature macro: FETCH_BTFN_PREDICT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [15:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        stall_i,
   input  logic        redirect_valid_i,
   input  logic [15:0] redirect_pc_i,
   output logic        ifid_valid_o,
   output logic [31:0] ifid_instr_o,
   output logic [15:0] ifid_pc_o,
   output logic [15:0] ifid_pc4_o,
   output logic        ifid_pred_taken_o
);

   state_t      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic        valid_q, valid_d;
   logic [31:0] instr_q, instr_d;
   logic [15:0] ifpc_q, ifpc_d;
   logic [15:0] ifpc4_q, ifpc4_d;
   logic        pred_q, pred_d;

   logic [15:0] pc4;
   logic [15:0] next_pc;
   logic        pred_taken;
   logic        is_halt;
   logic        unused_redirect_lsb;

   assign unused_redirect_lsb = ^redirect_pc_i[1:0];

   fetch_predecode u_predecode (
      .pc_i         (pc_q),
      .instr_i      (imem_rdata),
      .pc4_o        (pc4),
      .next_pc_o    (next_pc),
      .pred_taken_o (pred_taken),
      .is_halt_o    (is_halt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RUN;
         pc_q    <= RESET_PC;
         valid_q <= 1'b0;
         instr_q <= '0;
         ifpc_q  <= '0;
         ifpc4_q <= '0;
         pred_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         valid_q <= valid_d;
         instr_q <= instr_d;
         ifpc_q  <= ifpc_d;
         ifpc4_q <= ifpc4_d;
         pred_q  <= pred_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (redirect_valid_i) begin
         state_d = ST_RUN;
      end else if (!stall_i && (state_q == ST_RUN) && is_halt) begin
         state_d = ST_HALT;
      end
   end

   // Redirect beats stall; a stalled cycle holds every register.
   always_comb begin
      pc_d    = pc_q;
      valid_d = valid_q;
      instr_d = instr_q;
      ifpc_d  = ifpc_q;
      ifpc4_d = ifpc4_q;
      pred_d  = pred_q;
      if (redirect_valid_i) begin
         pc_d    = {redirect_pc_i[15:2], 2'b00};
         valid_d = 1'b0;
         instr_d = '0;
         pred_d  = 1'b0;
      end else if (!stall_i) begin
         case (state_q)
            ST_RUN: begin
               if (is_halt) begin
                  valid_d = 1'b0;
               end else begin
                  pc_d    = next_pc;
                  valid_d = 1'b1;
                  instr_d = imem_rdata;
                  ifpc_d  = pc_q;
                  ifpc4_d = pc4;
                  pred_d  = pred_taken;
               end
            end
            default: valid_d = 1'b0;
         endcase
      end
   end

   assign imem_addr         = pc_q;
   assign ifid_valid_o      = valid_q;
   assign ifid_instr_o      = instr_q;
   assign ifid_pc_o         = ifpc_q;
   assign ifid_pc4_o        = ifpc4_q;
   assign ifid_pred_taken_o = pred_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Self-checking bench for fetch_stage: directed vector table,
//               async-reset check, and randomized run against a fetch model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fetch_stage;

   localparam logic [15:0] RESET_PC = 16'h0000;
`ifdef FETCH_BTFN_PREDICT_EN
   localparam bit BTFN = 1'b1;
`else
   localparam bit BTFN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0;
   logic        rv = 1'b0;
   logic [15:0] rpc = 16'h0000;
   logic [15:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        ifid_valid;
   logic [31:0] ifid_instr;
   logic [15:0] ifid_pc;
   logic [15:0] ifid_pc4;
   logic        ifid_pred;

   logic [31:0] mem [0:16383];
   assign imem_rdata = mem[imem_addr[15:2]];

   always #5 clk = ~clk;

   fetch_stage #(.RESET_PC(RESET_PC)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .imem_addr         (imem_addr),
      .imem_rdata        (imem_rdata),
      .stall_i           (stall),
      .redirect_valid_i  (rv),
      .redirect_pc_i     (rpc),
      .ifid_valid_o      (ifid_valid),
      .ifid_instr_o      (ifid_instr),
      .ifid_pc_o         (ifid_pc),
      .ifid_pc4_o        (ifid_pc4),
      .ifid_pred_taken_o (ifid_pred)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        stall;
      logic        rv;
      logic [15:0] rpc;
      logic [15:0] addr;
      logic        valid;
      logic [31:0] instr;
      logic [15:0] pc;
      logic [15:0] pc4;
      logic        pred;
   } vec_t;
   vec_t tv[$];

   // Reference model state
   logic [15:0] m_pc;
   logic        m_valid;
   logic [31:0] m_instr;
   logic [15:0] m_ifpc;
   logic [15:0] m_pc4;
   logic        m_pred;
   bit          m_halted;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [15:0] addr, input logic valid,
                          input logic [31:0] instr, input logic [15:0] pc,
                          input logic [15:0] pc4, input logic pred);
      chk({tag, ".imem_addr"}, {16'h0, imem_addr}, {16'h0, addr});
      chk({tag, ".valid"}, {31'h0, ifid_valid}, {31'h0, valid});
      chk({tag, ".instr"}, ifid_instr, instr);
      chk({tag, ".pc"}, {16'h0, ifid_pc}, {16'h0, pc});
      chk({tag, ".pc4"}, {16'h0, ifid_pc4}, {16'h0, pc4});
      chk({tag, ".pred"}, {31'h0, ifid_pred}, {31'h0, pred});
   endtask

   task automatic add(input logic s, input logic r, input logic [15:0] rp,
                      input logic [15:0] a, input logic v, input logic [31:0] ins,
                      input logic [15:0] p, input logic [15:0] p4, input logic pr);
      vec_t e;
      e.stall = s; e.rv = r; e.rpc = rp; e.addr = a; e.valid = v;
      e.instr = ins; e.pc = p; e.pc4 = p4; e.pred = pr;
      tv.push_back(e);
   endtask

   task automatic model_reset();
      m_pc = RESET_PC; m_valid = 1'b0; m_instr = '0; m_ifpc = '0;
      m_pc4 = '0; m_pred = 1'b0; m_halted = 1'b0;
   endtask

   task automatic model_step(input logic s, input logic r, input logic [15:0] rp);
      logic [31:0] word;
      int          off;
      bit          taken;
      word = mem[m_pc[15:2]];
      if (r) begin
         m_pc = rp & 16'hFFFC;
         m_valid = 1'b0; m_instr = '0; m_pred = 1'b0; m_halted = 1'b0;
      end else if (s || m_halted) begin
         // nothing moves
      end else if (word == 32'hFFFF_FFFF) begin
         m_halted = 1'b1;
         m_valid = 1'b0;
      end else begin
         taken = BTFN && (word[31:26] == 6'd40 || word[31:26] == 6'd41) && word[15];
         off = int'($signed(word[15:0])) * 4;
         m_instr = word;
         m_ifpc = m_pc;
         m_pc4 = 16'(int'(m_pc) + 4);
         m_valid = 1'b1;
         m_pred = taken;
         m_pc = taken ? 16'(int'(m_pc) + 4 + off) : 16'(int'(m_pc) + 4);
      end
   endtask

   initial begin
      logic [31:0] w;
      for (int i = 0; i < 16384; i++) mem[i] = 32'h0000_0000;
      mem[16'h0018 >> 2] = 32'hA540_FFFD;
      mem[16'h0024 >> 2] = 32'hFFFF_FFFF;

      // ---------------- reset and directed table ----------------
      repeat (3) @(negedge clk);
      chk_all("reset", RESET_PC, 1'b0, 32'h0, 16'h0, 16'h0, 1'b0);
      rst_n = 1'b1;
      #1;
      chk_all("release", 16'h0000, 1'b0, 32'h0, 16'h0, 16'h0, 1'b0);

      add(0,0,16'h0, 16'h0004,1,32'h0,16'h0000,16'h0004,0);
      add(0,0,16'h0, 16'h0008,1,32'h0,16'h0004,16'h0008,0);
      for (int i = 0; i < 3; i++)
         add(1,0,16'h0, 16'h0008,1,32'h0,16'h0004,16'h0008,0);
      add(0,0,16'h0, 16'h000C,1,32'h0,16'h0008,16'h000C,0);
      add(0,0,16'h0, 16'h0010,1,32'h0,16'h000C,16'h0010,0);
      add(0,0,16'h0, 16'h0014,1,32'h0,16'h0010,16'h0014,0);
      add(0,0,16'h0, 16'h0018,1,32'h0,16'h0014,16'h0018,0);
      add(0,0,16'h0, BTFN ? 16'h0010 : 16'h001C,1,32'hA540FFFD,16'h0018,16'h001C,BTFN);
      add(1,1,16'h001E, 16'h001C,0,32'h0,16'h0018,16'h001C,0);
      add(0,0,16'h0, 16'h0020,1,32'h0,16'h001C,16'h0020,0);
      add(0,0,16'h0, 16'h0024,1,32'h0,16'h0020,16'h0024,0);
      add(0,0,16'h0, 16'h0024,0,32'h0,16'h0020,16'h0024,0);
      for (int i = 0; i < 10; i++)
         add(i == 4,0,16'h0, 16'h0024,0,32'h0,16'h0020,16'h0024,0);
      add(0,1,16'h0004, 16'h0004,0,32'h0,16'h0020,16'h0024,0);
      add(0,0,16'h0, 16'h0008,1,32'h0,16'h0004,16'h0008,0);
      add(0,1,16'hFFFC, 16'hFFFC,0,32'h0,16'h0004,16'h0008,0);
      add(0,0,16'h0, 16'h0000,1,32'h0,16'hFFFC,16'h0000,0);
      add(0,1,16'h0013, 16'h0010,0,32'h0,16'hFFFC,16'h0000,0);
      add(0,0,16'h0, 16'h0014,1,32'h0,16'h0010,16'h0014,0);

      for (int i = 0; i < tv.size(); i++) begin
         stall = tv[i].stall; rv = tv[i].rv; rpc = tv[i].rpc;
         @(posedge clk);
         @(negedge clk);
         chk_all($sformatf("vec%0d", i), tv[i].addr, tv[i].valid, tv[i].instr,
                 tv[i].pc, tv[i].pc4, tv[i].pred);
      end
      stall = 1'b0; rv = 1'b0;

      // ---------------- asynchronous reset mid-cycle ----------------
      #2 rst_n = 1'b0;
      #1;
      chk_all("async_rst", RESET_PC, 1'b0, 32'h0, 16'h0, 16'h0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // ---------------- randomized run vs model ----------------
      for (int i = 0; i < 16384; i++) begin
         int r;
         r = $urandom_range(0, 99);
         w = $urandom;
         if (r < 15) w[31:26] = ($urandom_range(0, 1) == 0) ? 6'b101000 : 6'b101001;
         else if (r < 17) w = 32'hFFFF_FFFF;
         mem[i] = w;
      end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      for (int c = 0; c < 3000; c++) begin
         chk_all($sformatf("rand%0d", c), m_pc, m_valid, m_instr, m_ifpc, m_pc4, m_pred);
         stall = ($urandom_range(0, 99) < 20);
         rv    = ($urandom_range(0, 99) < 8);
         rpc   = 16'($urandom);
         model_step(stall, rv, rpc);
         @(posedge clk);
         @(negedge clk);
      end
      chk_all("rand_end", m_pc, m_valid, m_instr, m_ifpc, m_pc4, m_pred);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter: RESET_PC, 16'h0000, byte address of the first fetch after reset.
REQ-002 SHALL have port: clk  input  1  single clock, all state rising-edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: imem_addr  output  16  byte address to instruction memory; equals the current PC combinationally.
REQ-005 SHALL have port: imem_rdata  input  32  big-endian instruction word, combinational from imem_addr.
REQ-006 SHALL have port: stall_i  input  1  downstream cannot accept; hold PC and IF/ID.
REQ-007 SHALL have port: redirect_valid_i  input  1  branch resolved or mispredicted; load redirect_pc_i.
REQ-008 SHALL have port: redirect_pc_i  input  16  redirect target byte address.
REQ-009 SHALL have port: ifid_valid_o  output  1  IF/ID holds a real instruction.
REQ-010 SHALL have port: ifid_instr_o  output  32  registered instruction.
REQ-011 SHALL have port: ifid_pc_o  output  16  address of ifid_instr_o.
REQ-012 SHALL have port: ifid_pc4_o  output  16  ifid_pc_o+4, modulo 2^16.
REQ-013 SHALL have port: ifid_pred_taken_o  output  1  fetch predicted the branch taken.

Function
REQ-014 SHALL run FSM states RUN and HALT.
REQ-015 In RUN, with no stall and no redirect, SHALL each cycle: register imem_rdata, PC and PC+4 into IF/ID; set ifid_valid_o=1; set PC to next-PC.
REQ-016 Default next-PC SHALL be PC+4, 16-bit wrap (16'hFFFC -> 16'h0000).
REQ-017 With stall_i=1 and no redirect, SHALL hold PC, all IF/ID outputs and the state.
REQ-018 With redirect_valid_i=1, SHALL, regardless of stall_i or state, load PC={redirect_pc_i[15:2],2'b00}, clear ifid_valid_o, set ifid_instr_o=0, ifid_pred_taken_o=0, and enter RUN.
REQ-019 In RUN, fetching imem_rdata==32'hFFFFFFFF (erased memory) with no stall and no redirect SHALL enter HALT with PC held and ifid_valid_o=0.
REQ-020 In HALT, SHALL keep ifid_valid_o=0 and PC held; only a redirect exits HALT.
REQ-021 Branch fields: opcode=[31:26], rs=[25:21], rt=[20:16], imm=[15:0]; beq=6'b101000, bne=6'b101001.
REQ-022 Branch target SHALL be PC+4+(sign-extended imm<<2), truncated to 16 bits.

Reset
REQ-023 While rst_n=0, SHALL force PC=RESET_PC, state=RUN, ifid_valid_o=0, ifid_instr_o=0, ifid_pc_o=0, ifid_pc4_o=0, ifid_pred_taken_o=0.
REQ-024 Deassertion of rst_n SHALL make the first fetch address RESET_PC, with ifid_valid_o=1 one cycle later.

Configuration
REQ-025 With FETCH_BTFN_PREDICT_EN defined, a RUN fetch of beq/bne with imm[15]=1, no stall and no redirect SHALL set next-PC to the branch target and register ifid_pred_taken_o=1.
REQ-026 Without FETCH_BTFN_PREDICT_EN, next-PC SHALL always be PC+4 and ifid_pred_taken_o SHALL be constant 0.

Structure
REQ-027 Opcode constants (beq, bne), the HALT word 32'hFFFFFFFF and the state encoding SHALL live in the shared CPU package.
REQ-028 Predecode and branch-target computation SHALL be one sub-module, fetch_predecode; the PC/IF-ID registers and FSM stay in fetch_stage.

Verification
REQ-029 Reset, then release with RESET_PC=0 -> imem_addr 0x0000, 0x0004, 0x0008 on successive cycles; ifid_valid_o=1 from the second cycle.
REQ-030 bne r10,r0,-3 (32'hA540FFFD) fetched at 0x0018 with macro defined -> next imem_addr=0x0010, ifid_pred_taken_o=1, ifid_pc4_o=0x001C; without macro -> next imem_addr=0x001C, ifid_pred_taken_o=0.
REQ-031 stall_i=1 for 3 cycles at PC 0x0008 -> imem_addr and all ifid_* outputs unchanged; PC 0x000C the cycle after release.
REQ-032 redirect_valid_i=1, redirect_pc_i=0x001E with stall_i=1 -> imem_addr=0x001C next cycle, ifid_valid_o=0.
REQ-033 32'hFFFFFFFF fetched at 0x0024 -> HALT, imem_addr held at 0x0024, ifid_valid_o=0 for 10 cycles; redirect to 0x0004 -> RUN, fetch at 0x0004.
REQ-034 PC reaches 0xFFFC -> next imem_addr=0x0000, ifid_pc4_o=0x0000.
